// File: rtl/nes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nes_pkg
// Description : Shared NES definitions: OAM DMA state encoding and the CPU
//               register addresses used as defaults by oam_dma.
// Revision    : 1.0 - initial release
// ============================================================================
package nes_pkg;

  // OAM DMA controller states (explicit 3-bit encoding)
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

endpackage : nes_pkg
`default_nettype wire

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma
// Description : Sprite OAM DMA controller (CPU clock domain). A CPU write to
//               DMA_REG_ADDR stalls the CPU and copies 256 bytes from page
//               {P,00}..{P,FF} to OAMDATA_ADDR, arbitrating the system bus
//               between the CPU and the DMA engine.
// Ports       : clk, rst         - CPU clock, async active-high reset
//               cpu_addr/rw/data_o - CPU bus request
//               rdy              - CPU ready (0 stalls the CPU)
//               bus_addr/rw/data_o - arbitrated bus request
//               bus_data_i       - bus read data (same cycle as read)
//               dma_active       - DMA owns the bus
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma
  import nes_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = ADDR_OAMDMA,
  parameter logic [15:0] OAMDATA_ADDR = ADDR_OAMDATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_data_o,
  output logic        rdy,
  output logic [15:0] bus_addr,
  output logic        bus_rw,
  output logic [7:0]  bus_data_o,
  input  logic [7:0]  bus_data_i,
  output logic        dma_active
);

  dma_state_t r_state;
  logic       r_odd;
  logic [7:0] r_page;
  logic [7:0] r_idx;
  logic [7:0] r_data_q;

  logic       w_trigger;

  // Only CPU writes start a transfer; reads of the DMA register are inert.
  assign w_trigger = (cpu_addr == DMA_REG_ADDR) && !cpu_rw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_odd    <= 1'b0;
      r_page   <= 8'h00;
      r_idx    <= 8'h00;
      r_data_q <= 8'h00;
    end else begin
      // Free-running parity: reads must land on even cycles, writes on odd.
      r_odd <= ~r_odd;
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_page  <= cpu_data_o;
            r_state <= HALT;
          end
        end
        HALT: begin
          // If the next cycle is even we can read immediately; otherwise
          // burn one ALIGN cycle to get onto the read phase.
          r_state <= r_odd ? READ : ALIGN;
        end
        ALIGN: begin
          r_state <= READ;
        end
        READ: begin
          r_data_q <= bus_data_i;
          r_state  <= WRITE;
        end
        WRITE: begin
          r_idx   <= r_idx + 8'd1;
          r_state <= (r_idx == 8'hFF) ? IDLE : READ;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rdy        = (r_state == IDLE);
  assign dma_active = !rdy;

  // Bus arbitration: CPU passthrough in IDLE, DMA-driven otherwise. HALT and
  // ALIGN issue a harmless read of the current source address.
  always_comb begin
    bus_addr   = cpu_addr;
    bus_rw     = cpu_rw;
    bus_data_o = cpu_data_o;
    case (r_state)
      IDLE: begin
        bus_addr   = cpu_addr;
        bus_rw     = cpu_rw;
        bus_data_o = cpu_data_o;
      end
      WRITE: begin
        bus_addr   = OAMDATA_ADDR;
        bus_rw     = 1'b0;
        bus_data_o = r_data_q;
      end
      default: begin
        bus_addr   = {r_page, r_idx};
        bus_rw     = 1'b1;
        bus_data_o = r_data_q;
      end
    endcase
  end

endmodule : oam_dma
`default_nettype wire

// File: doc/oam_dma.md
# oam_dma

Sprite OAM DMA controller on the CPU clock domain. A CPU write to $4014 makes it take over the CPU bus: it stalls the CPU, then copies 256 bytes from CPU page `{P,8'h00}`..`{P,8'hFF}` into the PPU through repeated writes to OAMDATA ($2004). It sits between `cpu_sim`/CPU core and the system bus decode, arbitrating the bus between the CPU and itself.

## Interface
Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA
- OAMDATA_ADDR, 16'h2004, destination address of every DMA write

Ports:
- clk  in  1  CPU clock (`clk_cpu`)
- rst  in  1  reset, asynchronous, active-high
- cpu_addr  in  16  CPU address
- cpu_rw  in  1  CPU direction, 1 = read
- cpu_data_o  in  8  CPU write data
- rdy  out  1  CPU ready; 0 stalls the CPU
- bus_addr  out  16  arbitrated bus address
- bus_rw  out  1  arbitrated bus direction, 1 = read
- bus_data_o  out  8  arbitrated bus write data
- bus_data_i  in  8  bus read data, valid in the same cycle as the read
- dma_active  out  1  DMA owns the bus

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- Parity flop `odd`:
  - Reset to 0, toggles every clk.
  - Every READ cycle has odd==0; every WRITE cycle has odd==1.
- Trigger: in IDLE, a cycle with cpu_addr==DMA_REG_ADDR and cpu_rw==0 latches `page <= cpu_data_o` and moves to HALT. The triggering write still passes through to the bus.
- HALT: one cycle. Next state is READ if the next cycle has odd==0, otherwise ALIGN.
- ALIGN: one idle cycle. bus_rw=1, bus_addr={page,idx}, read data discarded. Next state is READ.
- READ:
  - bus_addr={page,idx}, bus_rw=1.
  - `data_q <= bus_data_i`.
  - Next state is WRITE.
- WRITE:
  - bus_addr=OAMDATA_ADDR, bus_rw=0, bus_data_o=data_q.
  - `idx <= idx+1` (8-bit, wraps).
  - If idx==8'hFF, next state is IDLE; otherwise READ.
- Bus mux:
  - In IDLE, bus_* = cpu_addr/cpu_rw/cpu_data_o combinationally.
  - In all other states, bus_* are driven by the DMA.
- rdy = (state==IDLE). dma_active = !rdy.
- Triggers while not in IDLE are ignored; the stalled CPU holds its address.
- Reads of $4014 (cpu_rw==1) never trigger.
- Any page is legal, including $20 (PPU register mirrors) and $40. Source addresses are issued verbatim, with no special-casing.
- Reset at any time: state→IDLE, idx→0, page→0, data_q→0, odd→0. The bus returns to CPU passthrough immediately (asynchronous).

## Timing
- Reset values: rdy=1, dma_active=0, bus_* = CPU passthrough.
- Trigger write in cycle N:
  - rdy falls in cycle N+1 (registered state), the HALT cycle.
  - First READ is in N+2, or N+3 if ALIGN is inserted.
- Stall length (rdy low):
  - 513 cycles when the HALT cycle has odd==1.
  - 514 cycles when the HALT cycle has odd==0.
- Last WRITE (idx FF) is followed by IDLE on the next clk: rdy=1 and the CPU resumes.
- Each byte is read in cycle k and written in cycle k+1. Source order is ascending idx 00..FF.
- The PPU `cpu_cs` phase pulse is formed downstream from bus_addr; this block adds no extra latency beyond the one-cycle HALT.

## Structure
- Shared package `nes_pkg`:
  - `dma_state_t` enum (IDLE, HALT, ALIGN, READ, WRITE).
  - Address constants ADDR_OAMDMA=16'h4014 and ADDR_OAMDATA=16'h2004, used as the parameter defaults.
- Single module, no sub-modules. The bus mux is a combinational process inside `oam_dma`.
- Registers: state, odd, page[7:0], idx[7:0], data_q[7:0].

## Test plan
- Reset with rst=1 mid-stream, CPU writes $2005 → bus_* mirror CPU, rdy=1, dma_active=0.
- Write $02→$4014 with the HALT cycle odd → rdy low exactly 513 cycles. Bus sequence: read $0200, write $2004, …, read $02FF, write $2004. The memory model's OAM receives bytes 00..FF in order.
- Same trigger with the HALT cycle even → exactly 514 low cycles, one ALIGN cycle (read of $0200 discarded). Every READ falls on odd==0.
- Second write to $4014 (value $05) issued at DMA idx $40 → ignored. Transfer continues from page $02 and completes at 513/514 cycles.
- Assert rst at idx $80 during WRITE:
  - rdy=1 and passthrough in the same cycle.
  - A fresh $4014 write afterwards restarts from idx 0.
- Read of $4014 (cpu_rw=1) → no DMA, rdy stays 1. Write $FF→$4014 → source addresses $FF00..$FFFF, with idx wrap ending in IDLE.
